// File: rtl/crop_pkg.sv
// rtl/crop_pkg.sv - shared geometry defaults, counter widths and state type for the crop stage
package crop_pkg;

  localparam int DEF_PIXEL_BIT_WIDTH = 16;
  localparam int DEF_IN_ROWS         = 100;
  localparam int DEF_IN_COLS         = 160;
  localparam int DEF_OUT_ROWS        = 48;
  localparam int DEF_OUT_COLS        = 48;

  localparam int DEF_COL_W = $clog2(DEF_IN_COLS);
  localparam int DEF_ROW_W = $clog2(DEF_IN_ROWS);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } crop_state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// rtl/axis_pipe_reg.sv - single-stage ready/valid register carrying data, user and last
module axis_pipe_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tuser,
  output logic              m_tlast
);

  assign s_tready = !m_tvalid || m_tready;

  // Payload only loads with a valid beat, so it stays put while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tuser <= s_tuser;
        m_tlast <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/crop_window.sv
// rtl/crop_window.sv - forwards the OUT_ROWS x OUT_COLS window of each raster-order input frame
module crop_window
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int IN_ROWS         = DEF_IN_ROWS,
  parameter int IN_COLS         = DEF_IN_COLS,
  parameter int OUT_ROWS        = DEF_OUT_ROWS,
  parameter int OUT_COLS        = DEF_OUT_COLS
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0] crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       frame_done,
  output logic                       err_short_frame
);

  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);

  localparam logic [CW-1:0] X0_MAX   = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] Y0_MAX   = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW:0]   COLS_M1  = (CW+1)'(OUT_COLS - 1);
  localparam logic [RW:0]   ROWS_M1  = (RW+1)'(OUT_ROWS - 1);

  crop_state_t state, state_nxt;

  logic [CW-1:0] col, cur_col, x0_q, x0_in, x0_eff;
  logic [RW-1:0] row, cur_row, y0_q, y0_in, y0_eff;
  logic [CW:0]   col_ext, x_lo, x_last;
  logic [RW:0]   row_ext, y_lo, y_last;
  logic          beat, sof, active, keep;
  logic          at_eol, at_eof;
  logic          first_px, eol_px, last_px;
  logic          pipe_ready, final_q;

  assign beat   = s_axis_tvalid && s_axis_tready;
  assign sof    = beat && s_axis_tuser;
  assign active = sof || (state == ACTIVE);

  // An SOF beat is its own pixel (0,0) with freshly sampled, clamped crop origin.
  assign x0_in   = (crop_x0 > X0_MAX) ? X0_MAX : crop_x0;
  assign y0_in   = (crop_y0 > Y0_MAX) ? Y0_MAX : crop_y0;
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign x0_eff  = sof ? x0_in : x0_q;
  assign y0_eff  = sof ? y0_in : y0_q;

  assign col_ext = {1'b0, cur_col};
  assign row_ext = {1'b0, cur_row};
  assign x_lo    = {1'b0, x0_eff};
  assign y_lo    = {1'b0, y0_eff};
  assign x_last  = x_lo + COLS_M1;
  assign y_last  = y_lo + ROWS_M1;

  assign keep     = beat && active &&
                    (col_ext >= x_lo) && (col_ext <= x_last) &&
                    (row_ext >= y_lo) && (row_ext <= y_last);
  assign first_px = (row_ext == y_lo) && (col_ext == x_lo);
  assign eol_px   = (col_ext == x_last);
  assign last_px  = eol_px && (row_ext == y_last);

  assign at_eol = (cur_col == COL_LAST);
  assign at_eof = at_eol && (cur_row == ROW_LAST);

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sof) begin
      state_nxt = ACTIVE;
    end
    if (beat && active && at_eof) begin
      state_nxt = WAIT_SOF;
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      col             <= '0;
      row             <= '0;
      x0_q            <= '0;
      y0_q            <= '0;
      err_short_frame <= 1'b0;
    end else begin
      if (sof) begin
        x0_q <= x0_in;
        y0_q <= y0_in;
      end
      // Leaving ACTIVE happens only on the final pixel, so SOF here means a truncated frame.
      if (sof && (state == ACTIVE)) begin
        err_short_frame <= 1'b1;
      end
      if (beat && active) begin
        if (at_eol) begin
          col <= '0;
          row <= at_eof ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  logic [PIXEL_BIT_WIDTH:0] pipe_data;

  axis_pipe_reg #(
    .DATA_W(PIXEL_BIT_WIDTH + 1)
  ) u_out_reg (
    .clk      (clk),
    .resetn   (s_axis_resetn),
    .s_tvalid (keep),
    .s_tready (pipe_ready),
    .s_tdata  ({last_px, s_axis_tdata}),
    .s_tuser  (first_px),
    .s_tlast  (eol_px),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready),
    .m_tdata  (pipe_data),
    .m_tuser  (m_axis_tuser),
    .m_tlast  (m_axis_tlast)
  );

  assign m_axis_tdata  = pipe_data[PIXEL_BIT_WIDTH-1:0];
  assign final_q       = pipe_data[PIXEL_BIT_WIDTH];
  assign s_axis_tready = s_axis_resetn && pipe_ready;
  assign frame_done    = m_axis_tvalid && m_axis_tready && final_q;

endmodule
